uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a configurable frame format: data width, parity mode, stop-bit count and bit order. Per-word error flags are stored with each received word in a small first-word-fall-through (FWFT) receive FIFO, read through a valid/ready handshake. The block sits between the board RX pin and the consumer logic. It is the next generation of the single-byte, ready-flag receiver.

Parameters:
CLKS_PER_BIT, 1302, clk cycles per bit period; minimum 8
DATA_BITS, 8, data bits per frame; range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
LSB_FIRST, 1, 1 = first received bit goes to o_data[0]; 0 = first received bit goes to o_data[DATA_BITS-1]
FIFO_DEPTH, 4, receive FIFO entries; power of 2, at least 2

Ports:
clk  in  1  system clock
i_reset  in  1  reset, asynchronous, active-high
i_rx  in  1  serial line, asynchronous to clk, idles high
o_data  out  DATA_BITS  head FIFO word; valid when o_valid=1
o_parity_err  out  1  parity error flag of the head word
o_frame_err  out  1  framing error flag of the head word
o_valid  out  1  FIFO not empty
i_ready  in  1  consumer accepts the head word; a pop occurs when o_valid && i_ready
o_overrun  out  1  sticky: a word was dropped because the FIFO was full
i_clear_err  in  1  synchronous clear of o_overrun
o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async): state IDLE, bit counter 0, shift register 0, FIFO empty. o_valid=0, o_count=0, o_overrun=0, o_data=0, both error flags 0. The two i_rx synchroniser flops reset to 1.
- i_rx passes through a 2-flop synchroniser (rxs) before any use; this is 2 cycles of latency. Edge detection uses rxs and its previous value.
- Timer: counts clk cycles. It is cleared on every state change and on every bit sample. HALF = CLKS_PER_BIT/2 (integer division).
- FSM states:
  - IDLE: a falling edge on rxs moves to START.
  - START: at timer = HALF-1, sample rxs. If rxs=0, go to DATA with bit index 0. If rxs=1 (glitch), go back to IDLE; no word, no error.
  - DATA: sample rxs every CLKS_PER_BIT cycles, i.e. at bit centres. Shift the sample in according to LSB_FIRST. After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise to STOP.
  - PARITY: sample one bit. parity_err = 1 if the XOR of the data bits and the parity bit is 0 for odd parity, or 1 for even parity.
  - STOP: sample STOP_BITS bits, one per bit period. frame_err = 1 if any stop sample is 0.
    - At the final stop sample, push {data, parity_err, frame_err} in the same cycle.
    - If frame_err=0, go to IDLE.
    - If frame_err=1, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. A held-low line produces exactly one word.
- Push and pop:
  - A push that finds the FIFO full, with no pop in the same cycle, drops the word and sets o_overrun. The FIFO contents are unchanged.
  - A push and a pop in the same cycle while full both succeed; o_overrun is not set and o_count is unchanged.
  - A pop when empty is ignored.
  - o_valid and the head outputs update in the cycle after a push into an empty FIFO (1-cycle write latency).
  - Output words appear in arrival order.
- o_overrun stays at 1 until i_clear_err=1 at a clock edge. If a clear and a new overrun occur in the same cycle, the set wins.
- A push into a non-full FIFO never sets an error flag on any other entry. Error flags travel with their word only.
- A new frame can start in the cycle after STOP returns to IDLE; back-to-back frames with no idle gap must be received.
- Reset mid-frame aborts the frame and empties the FIFO. No partial word is pushed.

Test Plan:
- The bench uses CLKS_PER_BIT=16 and drives each bit for exactly 16 cycles.
- 8N1, send 0xA5 with LSB_FIRST=1 -> o_valid rises 154±2 cycles after the start-bit falling edge; o_data=0xA5; both error flags 0; o_count=1. Pop with i_ready=1 -> o_valid=0 next cycle.
- PARITY=2, DATA_BITS=7: send 0x03 with parity bit 1 (wrong) -> o_data=0x03, o_parity_err=1. Then send 0x03 with parity bit 0 -> o_parity_err=0.
- 8N1 frame 0x3C with stop bit 0, line then held low 64 cycles, then high, then 0x55 sent -> word 0x3C with o_frame_err=1 is followed by exactly one more word, 0x55 with o_frame_err=0.
- Glitch: i_rx low for 4 cycles, then high -> no push, o_count stays 0, FSM back in IDLE.
- FIFO_DEPTH=4, i_ready=0: send bytes 0x01..0x05 back-to-back -> o_count=4, o_overrun=1. Pops return 0x01..0x04 in order; 0x05 is lost. Pulse i_clear_err -> o_overrun=0.
- Assert i_reset during data bit 3 of a frame, with 2 words already queued -> o_valid=0, o_count=0, o_overrun=0. The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: configurable UART receiver storing per-word parity/framing flags in an FWFT FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_rx,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_overrun,
  input  logic                          i_clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t state, state_n;
  logic rx_meta, rxs, rxs_d;
  logic [TW-1:0] timer;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic parity_err, frame_err, ferr_n, sample, push, pop, full, wr_en;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [WW-1:0] head;
  always_ff @(posedge clk or posedge i_reset)
    if (i_reset) {rx_meta, rxs, rxs_d} <= '1;
    else {rx_meta, rxs, rxs_d} <= {i_rx, rx_meta, rxs};
  assign sample = state == START ? timer == HALF_M1
                : (state == DATA || state == PAR || state == STOP) && timer == FULL_M1;
  assign ferr_n = frame_err | ~rxs;
  always_comb begin
    state_n = state;
    push = 1'b0;
    case (state)
      IDLE:  if (rxs_d && !rxs) state_n = START;
      START: if (sample) state_n = rxs ? IDLE : DATA;
      DATA:  if (sample && bit_cnt == LAST_D) state_n = PARITY != 0 ? PAR : STOP;
      PAR:   if (sample) state_n = STOP;
      STOP:  if (sample && bit_cnt == LAST_S) begin
        push = 1'b1;
        state_n = ferr_n ? BRK : IDLE;
      end
      BRK:   if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      timer <= '0;
      bit_cnt <= '0;
      shift <= '0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (state_n != state || sample || state == IDLE) ? '0 : timer + 1'b1;
      bit_cnt <= state_n != state ? '0 : sample ? bit_cnt + 1'b1 : bit_cnt;
      if (sample && state == DATA)
        shift <= LSB_FIRST != 0 ? {rxs, shift[DATA_BITS-1:1]} : {shift[DATA_BITS-2:0], rxs};
      parity_err <= state == IDLE ? 1'b0
                  : sample && state == PAR ? ^shift ^ rxs ^ (PARITY == 1) : parity_err;
      frame_err <= state == IDLE ? 1'b0 : sample && state == STOP ? ferr_n : frame_err;
    end
  assign o_count = wr_ptr - rd_ptr;
  assign o_valid = o_count != '0;
  assign full = o_count == DEPTH;
  assign pop = o_valid && i_ready;
  assign wr_en = push && (!full || pop);
  assign head = o_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign {o_parity_err, o_frame_err, o_data} = head;
  always_ff @(posedge clk or posedge i_reset)
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_overrun <= (push && full && !pop) || (o_overrun && !i_clear_err);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {parity_err, ferr_n, shift};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed, table-driven and randomized checks of two uart_rx_fifo frame formats
module tb_uart_rx_fifo;
  logic clk = 1'b0, i_reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic perr_a, ferr_a, val_a, ovr_a, perr_b, ferr_b, val_b, ovr_b;
  logic [2:0] cnt_a, cnt_b;
  int checks = 0, errors = 0;
  logic done;
  logic [6:0] r_d;
  logic r_p, r_rdy;
  logic [1:0] r_st;
  int lat;
  typedef struct { logic [6:0] d; logic p; logic [6:0] exp_d; logic exp_perr; } pvec_t;
  typedef struct { logic [6:0] d; logic perr; logic ferr; } word_t;
  pvec_t vecs[6];
  word_t model_q[$];
  word_t w;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .LSB_FIRST(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .i_reset(i_reset), .i_rx(rx_a), .o_data(data_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_valid(val_a), .i_ready(rdy_a), .o_overrun(ovr_a),
    .i_clear_err(clr_a), .o_count(cnt_a));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                 .LSB_FIRST(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .i_reset(i_reset), .i_rx(rx_b), .o_data(data_b), .o_parity_err(perr_b),
    .o_frame_err(ferr_b), .o_valid(val_b), .i_ready(rdy_b), .o_overrun(ovr_b),
    .i_clear_err(clr_b), .o_count(cnt_b));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input bit b_inst, input logic v);
    if (b_inst) rx_b = v; else rx_a = v;
    repeat (16) @(negedge clk);
  endtask

  // Instance b is MSB first, so its data bits go out from d[6] down to d[0].
  task automatic send(input bit b_inst, input logic [7:0] d, input logic p, input logic [1:0] stop);
    drive_bit(b_inst, 1'b0);
    for (int i = 0; i < (b_inst ? 7 : 8); i++) drive_bit(b_inst, b_inst ? d[6-i] : d[i]);
    if (b_inst) drive_bit(1'b1, p);
    drive_bit(b_inst, stop[0]);
    if (b_inst) drive_bit(1'b1, stop[1]);
  endtask

  task automatic wait_valid(input bit b_inst, input string nm);
    int n;
    n = 0;
    while (!(b_inst ? val_b : val_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_wait"}, int'(b_inst ? val_b : val_a), 1);
  endtask

  task automatic pop_chk(input bit b_inst, input string nm, input int d, input int pe, input int fe);
    chk({nm, "_valid"}, int'(b_inst ? val_b : val_a), 1);
    chk({nm, "_data"}, b_inst ? int'(data_b) : int'(data_a), d);
    chk({nm, "_perr"}, int'(b_inst ? perr_b : perr_a), pe);
    chk({nm, "_ferr"}, int'(b_inst ? ferr_b : ferr_a), fe);
    if (b_inst) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  initial begin
    vecs[0] = '{7'h03, 1'b1, 7'h03, 1'b1};
    vecs[1] = '{7'h03, 1'b0, 7'h03, 1'b0};
    vecs[2] = '{7'h7F, 1'b1, 7'h7F, 1'b0};
    vecs[3] = '{7'h7F, 1'b0, 7'h7F, 1'b1};
    vecs[4] = '{7'h40, 1'b1, 7'h40, 1'b0};
    vecs[5] = '{7'h2A, 1'b1, 7'h2A, 1'b0};
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(val_a), 0);
    chk("rst_count", int'(cnt_a), 0);
    chk("rst_overrun", int'(ovr_a), 0);
    chk("rst_data", int'(data_a), 0);
    chk("rst_perr", int'(perr_a), 0);
    chk("rst_ferr", int'(ferr_a), 0);
    chk("rst_valid_b", int'(val_b), 0);

    lat = 0;
    fork
      send(1'b0, 8'hA5, 1'b0, 2'b11);
      while (!val_a && lat < 300) begin
        @(negedge clk);
        lat++;
      end
    join
    checks++;
    if (lat < 152 || lat > 156) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected 152..156", lat);
    end
    chk("a5_count", int'(cnt_a), 1);
    pop_chk(1'b0, "a5", 'hA5, 0, 0);
    chk("a5_popped", int'(val_a), 0);

    for (int i = 0; i < 6; i++) begin
      send(1'b1, {1'b0, vecs[i].d}, vecs[i].p, 2'b11);
      wait_valid(1'b1, $sformatf("par%0d", i));
      pop_chk(1'b1, $sformatf("par%0d", i), int'(vecs[i].exp_d), int'(vecs[i].exp_perr), 0);
    end

    send(1'b0, 8'h3C, 1'b0, 2'b00);
    repeat (64) @(negedge clk);
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    send(1'b0, 8'h55, 1'b0, 2'b11);
    repeat (20) @(negedge clk);
    chk("brk_count", int'(cnt_a), 2);
    pop_chk(1'b0, "brk0", 'h3C, 0, 1);
    pop_chk(1'b0, "brk1", 'h55, 0, 0);
    chk("brk_empty", int'(cnt_a), 0);

    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", int'(cnt_a), 0);
    chk("glitch_valid", int'(val_a), 0);
    send(1'b0, 8'h96, 1'b0, 2'b11);
    wait_valid(1'b0, "post_glitch");
    pop_chk(1'b0, "post_glitch", 'h96, 0, 0);

    for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    chk("ovr_count", int'(cnt_a), 4);
    chk("ovr_set", int'(ovr_a), 1);
    for (int i = 1; i <= 4; i++) pop_chk(1'b0, $sformatf("ovr%0d", i), i, 0, 0);
    chk("ovr_drained", int'(cnt_a), 0);
    chk("ovr_sticky", int'(ovr_a), 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("ovr_cleared", int'(ovr_a), 0);

    send(1'b0, 8'h11, 1'b0, 2'b11);
    send(1'b0, 8'h22, 1'b0, 2'b11);
    chk("mid_queued", int'(cnt_a), 2);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("mid_valid", int'(val_a), 0);
    chk("mid_count", int'(cnt_a), 0);
    chk("mid_overrun", int'(ovr_a), 0);
    repeat (32) @(negedge clk);
    send(1'b0, 8'h7E, 1'b0, 2'b11);
    wait_valid(1'b0, "after_rst");
    pop_chk(1'b0, "after_rst", 'h7E, 0, 0);
    chk("after_rst_empty", int'(cnt_a), 0);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          r_d = 7'($urandom);
          r_p = 1'($urandom);
          r_st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
          model_q.push_back('{r_d, ^r_d ^ r_p, ~&r_st});
          send(1'b1, {1'b0, r_d}, r_p, r_st);
          rx_b = 1'b1;
          if (r_st != 2'b11) repeat (24) @(negedge clk);
        end
        repeat (100) @(negedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          r_rdy = ($urandom_range(0, 3) == 0);
          if (r_rdy && val_b) begin
            if (model_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rand_extra: got word 0x%0h, expected none", data_b);
            end else begin
              w = model_q.pop_front();
              chk("rand_data", int'(data_b), int'(w.d));
              chk("rand_perr", int'(perr_b), int'(w.perr));
              chk("rand_ferr", int'(ferr_b), int'(w.ferr));
            end
          end
          rdy_b = r_rdy;
        end
        rdy_b = 1'b0;
      end
    join
    chk("rand_left", model_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
